// File: rtl/base_sys_pio_multi.sv
// Multi-bit Avalon-MM PIO: synchronised input with per-bit edge capture and
// interrupt mask, plus an output register with atomic set/clear writes.
module base_sys_pio_multi #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] RESET_OUT     = '0,
    parameter logic [WIDTH-1:0] RESET_RISE_EN = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_OUTSET   = 3'd1,
        REG_IRQ_MASK = 3'd2,
        REG_EDGE_CAP = 3'd3,
        REG_OUTCLR   = 3'd4,
        REG_RISE_EN  = 3'd5,
        REG_FALL_EN  = 3'd6,
        REG_NONE     = 3'd7
    } reg_addr_e;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      rd_mux;
    logic             wr;
    reg_addr_e        addr;
    logic             unused_writedata;

    assign addr     = reg_addr_e'(address);
    assign wr       = chipselect & ~write_n;
    assign wdata    = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;

    assign sync_in  = sync_q[SYNC_STAGES-1];
    assign rise     = sync_in & ~prev_in & rise_en_q;
    assign fall     = ~sync_in & prev_in & fall_en_q;
    assign clr      = (wr && addr == REG_EDGE_CAP) ? wdata : '0;

    // irq depends only on flops, so no pin-to-irq combinational path exists.
    assign irq      = |(cap_q & mask_q);
    assign out_port = out_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_in <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_in <= sync_in;
        end
    end

    // A fresh edge is OR-ed in after the clear, so it survives a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= (cap_q & ~clr) | rise | fall;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= RESET_OUT;
            mask_q    <= '0;
            rise_en_q <= RESET_RISE_EN;
            fall_en_q <= '0;
        end else if (wr) begin
            case (addr)
                REG_DATA:     out_q     <= wdata;
                REG_OUTSET:   out_q     <= out_q | wdata;
                REG_OUTCLR:   out_q     <= out_q & ~wdata;
                REG_IRQ_MASK: mask_q    <= wdata;
                REG_RISE_EN:  rise_en_q <= wdata;
                REG_FALL_EN:  fall_en_q <= wdata;
                default:      ;
            endcase
        end
    end

    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_DATA:     rd_mux = 32'(sync_in);
            REG_OUTSET,
            REG_OUTCLR:   rd_mux = 32'(out_q);
            REG_IRQ_MASK: rd_mux = 32'(mask_q);
            REG_EDGE_CAP: rd_mux = 32'(cap_q);
            REG_RISE_EN:  rd_mux = 32'(rise_en_q);
            REG_FALL_EN:  rd_mux = 32'(fall_en_q);
            default:      rd_mux = '0;
        endcase
    end

    // Read data is registered from address every cycle; chipselect is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_base_sys_pio_multi.sv
// Self-checking bench for base_sys_pio_multi: register table, hand-written
// edge/reset sequences and a randomized run against a queue-based model.
module tb_base_sys_pio_multi;

    localparam int W  = 8;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] out_port;
    logic        irq;

    always #5 clk = ~clk;

    base_sys_pio_multi #(
        .WIDTH        (W),
        .SYNC_STAGES  (SS),
        .RESET_OUT    (8'h00),
        .RESET_RISE_EN(8'hFF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .irq       (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: registers as plain variables; the synchroniser is just
    // the input history, with sync_in being the sample SS clocks old.
    logic [W-1:0] m_out, m_mask, m_cap, m_rise, m_fall;
    logic [31:0]  m_rd;
    logic [W-1:0] hist[$];

    task automatic model_reset();
        m_out  = 8'h00;
        m_mask = '0;
        m_cap  = '0;
        m_rise = 8'hFF;
        m_fall = '0;
        m_rd   = '0;
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back('0);
    endtask

    task automatic tick();
        logic [W-1:0] s, p, wd, clr, ev;
        logic         wr;
        if (!reset_n) begin
            model_reset();
        end else begin
            s  = hist[SS-1];
            p  = hist[SS];
            wr = chipselect && !write_n;
            wd = writedata[W-1:0];
            case (address)
                3'd0: m_rd = 32'(s);
                3'd1, 3'd4: m_rd = 32'(m_out);
                3'd2: m_rd = 32'(m_mask);
                3'd3: m_rd = 32'(m_cap);
                3'd5: m_rd = 32'(m_rise);
                3'd6: m_rd = 32'(m_fall);
                default: m_rd = 0;
            endcase
            clr = (wr && address == 3'd3) ? wd : '0;
            ev  = (s & ~p & m_rise) | (~s & p & m_fall);
            m_cap = (m_cap & ~clr) | ev;
            if (wr) begin
                case (address)
                    3'd0: m_out  = wd;
                    3'd1: m_out  = m_out | wd;
                    3'd2: m_mask = wd;
                    3'd4: m_out  = m_out & ~wd;
                    3'd5: m_rise = wd;
                    3'd6: m_fall = wd;
                    default: ;
                endcase
            end
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        check("model_out_port", 32'(out_port), 32'(m_out));
        check("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
        check("model_readdata", readdata, m_rd);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick();
        v = readdata;
        chipselect = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;

        vecs[0]  = '{3'd0, 1'b1, 32'h0000_000F, 8'h0F, 32'h00};
        vecs[1]  = '{3'd1, 1'b1, 32'h0000_0030, 8'h3F, 32'h0F};
        vecs[2]  = '{3'd4, 1'b1, 32'h0000_0003, 8'h3C, 32'h3F};
        vecs[3]  = '{3'd1, 1'b0, 32'h0,         8'h3C, 32'h3C};
        vecs[4]  = '{3'd4, 1'b0, 32'h0,         8'h3C, 32'h3C};
        vecs[5]  = '{3'd2, 1'b1, 32'h0000_00A5, 8'h3C, 32'h00};
        vecs[6]  = '{3'd2, 1'b0, 32'h0,         8'h3C, 32'hA5};
        vecs[7]  = '{3'd7, 1'b1, 32'h0000_00FF, 8'h3C, 32'h00};
        vecs[8]  = '{3'd7, 1'b0, 32'h0,         8'h3C, 32'h00};
        vecs[9]  = '{3'd5, 1'b0, 32'h0,         8'h3C, 32'hFF};
        vecs[10] = '{3'd6, 1'b1, 32'h0000_0012, 8'h3C, 32'h00};
        vecs[11] = '{3'd6, 1'b0, 32'h0,         8'h3C, 32'h12};
        vecs[12] = '{3'd2, 1'b1, 32'h0000_0000, 8'h3C, 32'hA5};
        vecs[13] = '{3'd0, 1'b1, 32'hFFFF_FF00, 8'h00, 32'h00};
        vecs[14] = '{3'd6, 1'b1, 32'h0000_0000, 8'h00, 32'h12};

        // Reset held with a write active.
        model_reset();
        chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'hFF;
        repeat (3) tick();
        check("reset_out_port", 32'(out_port), 32'h00);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_readdata", readdata, 32'h0);
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b1;
        rd_reg(3'd5, v);
        check("reset_rise_en", v, 32'hFF);

        // Register table.
        for (int i = 0; i < 15; i++) begin
            chipselect = 1'b1;
            write_n    = !vecs[i].wr;
            address    = vecs[i].addr;
            writedata  = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'h0);
        end
        chipselect = 1'b0; write_n = 1'b1;

        // Rising edge latency: irq exactly SS+1 clocks after the pin change.
        wr_reg(3'd2, 32'h01);
        in_port = 8'h01;
        tick(); check("rise_irq_c1", 32'(irq), 32'h0);
        tick(); check("rise_irq_c2", 32'(irq), 32'h0);
        tick(); check("rise_irq_c3", 32'(irq), 32'h1);
        rd_reg(3'd3, v);
        check("rise_cap", v, 32'h01);
        wr_reg(3'd3, 32'h01);
        check("rise_clear_irq", 32'(irq), 32'h0);

        // Falling edge only on bit 7.
        wr_reg(3'd5, 32'h00);
        wr_reg(3'd6, 32'h80);
        in_port = 8'hC1; repeat (4) tick();
        in_port = 8'h41; repeat (4) tick();
        rd_reg(3'd3, v);
        check("fall_bit7", v, 32'h80);
        in_port = 8'h01; repeat (4) tick();
        rd_reg(3'd3, v);
        check("fall_bit6_ignored", v, 32'h80);

        // New edge collides with its own clear.
        wr_reg(3'd3, 32'hFF);
        wr_reg(3'd5, 32'h01);
        wr_reg(3'd6, 32'h00);
        in_port = 8'h00; repeat (4) tick();
        in_port = 8'h01; repeat (4) tick();
        check("coll_pre_irq", 32'(irq), 32'h1);
        in_port = 8'h00; repeat (4) tick();
        in_port = 8'h01;
        tick(); tick();
        chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h01;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        check("coll_irq", 32'(irq), 32'h1);
        rd_reg(3'd3, v);
        check("coll_cap", v, 32'h01);

        // Reset in the middle of operation.
        wr_reg(3'd5, 32'hFF);
        wr_reg(3'd6, 32'hFF);
        wr_reg(3'd2, 32'hFF);
        wr_reg(3'd0, 32'h5A);
        in_port = 8'hFF; repeat (4) tick();
        rd_reg(3'd3, v);
        check("mid_cap_full", v, 32'hFF);
        check("mid_irq_before", 32'(irq), 32'h1);
        in_port = 8'h01;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_reset_irq", 32'(irq), 32'h0);
        check("mid_reset_out", 32'(out_port), 32'h00);
        tick();
        reset_n = 1'b1;
        wr_reg(3'd2, 32'h01);
        check("mid_irq_c1", 32'(irq), 32'h0);
        tick(); check("mid_irq_c2", 32'(irq), 32'h0);
        tick(); check("mid_irq_c3", 32'(irq), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
